// File: rtl/branch_redirect_unit.sv
// Program counter owner: advances the PC, redirects on taken branches and jumps,
// traps misaligned targets, and holds flush high for a fixed number of un-stalled slots.
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0010,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        jump,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_seq,
    output logic        flush,
    output logic        redirect,
    output logic        misalign
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] pc_nx;
    logic        redirect_nx, misalign_nx;
    logic        take;

    assign take = br_valid & (jump | br_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            pc       <= RESET_PC;
            redirect <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pc       <= pc_nx;
            redirect <= redirect_nx;
            misalign <= misalign_nx;
        end
    end

    // Branch inputs are ignored during FLUSH: they belong to squashed instructions.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pc_nx       = pc;
        redirect_nx = 1'b0;
        misalign_nx = 1'b0;
        case (state)
            RUN: begin
                if (take) begin
                    state_nx    = FLUSH;
                    cnt_nx      = CNT_INIT;
                    redirect_nx = 1'b1;
                    if (target[1:0] != 2'b00) begin
                        pc_nx       = TRAP_VEC;
                        misalign_nx = 1'b1;
                    end else begin
                        pc_nx = target;
                    end
                end else if (!stall) begin
                    pc_nx = pc_seq;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_nx = pc_seq;
                    if (cnt == 4'd0) state_nx = RUN;
                    else             cnt_nx   = cnt - 4'd1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        pc_seq = pc + 32'd4;
        flush  = (state == FLUSH);
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: each scenario checks {pc, flush, redirect, misalign}.
module tb_branch_redirect_unit;

    logic        clk, rst, stall, br_valid, br_taken, jump;
    logic [31:0] target, pc, pc_seq;
    logic        flush, redirect, misalign;
    int          total = 0;
    int          bad   = 0;

    branch_redirect_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .jump(jump), .target(target), .pc(pc), .pc_seq(pc_seq), .flush(flush),
        .redirect(redirect), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_valid = 0; br_taken = 0; jump = 0; target = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; idle();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h0, 3'b000}) begin
            bad++; $display("FAIL reset got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h0, 3'b000});
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if ({pc, flush, redirect, misalign} !== {32'(i * 4), 3'b000}) begin
                bad++; $display("FAIL advance%0d got=%h exp=%h", i, {pc, flush, redirect, misalign}, {32'(i * 4), 3'b000});
            end
        end
        total++;
        if (pc_seq !== 32'h10) begin
            bad++; $display("FAIL pc_seq got=%h exp=%h", pc_seq, 32'h10);
        end
    endtask

    task automatic test_taken();
        do_reset();
        step(); step();
        br_valid = 1; br_taken = 1; target = 32'h100;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h100, 3'b110}) begin
            bad++; $display("FAIL taken_load got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h100, 3'b110});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h104, 3'b100}) begin
            bad++; $display("FAIL taken_flush got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h104, 3'b100});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h108, 3'b000}) begin
            bad++; $display("FAIL taken_done got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h108, 3'b000});
        end
    endtask

    task automatic test_notaken_jump();
        br_valid = 1; br_taken = 0; jump = 0; target = 32'h500;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h10C, 3'b000}) begin
            bad++; $display("FAIL not_taken got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h10C, 3'b000});
        end
        br_valid = 0; br_taken = 1; target = 32'h600;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h110, 3'b000}) begin
            bad++; $display("FAIL taken_no_valid got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h110, 3'b000});
        end
        br_valid = 1; jump = 1; br_taken = 0; target = 32'h40;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h40, 3'b110}) begin
            bad++; $display("FAIL jump got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h40, 3'b110});
        end
        step(); step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h48, 3'b000}) begin
            bad++; $display("FAIL jump_done got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h48, 3'b000});
        end
    endtask

    task automatic test_misalign();
        br_valid = 1; jump = 1; target = 32'h102;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h10, 3'b111}) begin
            bad++; $display("FAIL misalign_trap got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h10, 3'b111});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h14, 3'b100}) begin
            bad++; $display("FAIL misalign_flush got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h14, 3'b100});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h18, 3'b000}) begin
            bad++; $display("FAIL misalign_done got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h18, 3'b000});
        end
    endtask

    task automatic test_stall();
        stall = 1; br_valid = 1; br_taken = 1; target = 32'h200;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h200, 3'b110}) begin
            bad++; $display("FAIL stall_load got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h200, 3'b110});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({pc, flush, redirect, misalign} !== {32'h200, 3'b100}) begin
                bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, {pc, flush, redirect, misalign}, {32'h200, 3'b100});
            end
        end
        stall = 0; br_valid = 1; br_taken = 1; target = 32'h300;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h204, 3'b100}) begin
            bad++; $display("FAIL flush_ignore got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h204, 3'b100});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h208, 3'b000}) begin
            bad++; $display("FAIL stall_done got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h208, 3'b000});
        end
        stall = 1;
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h208, 3'b000}) begin
            bad++; $display("FAIL run_stall got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h208, 3'b000});
        end
        stall = 0;
    endtask

    task automatic test_async_reset();
        br_valid = 1; jump = 1; target = 32'h80;
        step(); idle();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h80, 3'b110}) begin
            bad++; $display("FAIL pre_reset got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h80, 3'b110});
        end
        #2 rst = 1;
        #1;
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h0, 3'b000}) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h0, 3'b000});
        end
        rst = 0;
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h4, 3'b000}) begin
            bad++; $display("FAIL post_reset got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h4, 3'b000});
        end
    endtask

    task automatic test_wrap();
        br_valid = 1; jump = 1; target = 32'hFFFF_FFFC;
        step(); idle();
        total++;
        if ({pc, pc_seq, flush, redirect, misalign} !== {32'hFFFF_FFFC, 32'h0, 3'b110}) begin
            bad++; $display("FAIL wrap_load got=%h exp=%h", {pc, pc_seq, flush, redirect, misalign}, {32'hFFFF_FFFC, 32'h0, 3'b110});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h0, 3'b100}) begin
            bad++; $display("FAIL wrap_adv got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h0, 3'b100});
        end
        step();
        total++;
        if ({pc, flush, redirect, misalign} !== {32'h4, 3'b000}) begin
            bad++; $display("FAIL wrap_done got=%h exp=%h", {pc, flush, redirect, misalign}, {32'h4, 3'b000});
        end
    endtask

    initial begin
        rst = 1; stall = 0; idle();
        test_reset();
        test_taken();
        test_notaken_jump();
        test_misalign();
        test_stall();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer side of the branch-decision interface: takes the resolved taken/not-taken bit and the branch target, and owns the program counter.
- Redirects the PC on taken branches and jumps, then raises a flush window to squash wrong-path fetches.
- Routes misaligned targets to a trap vector.
- Sits between the branch-condition logic/ALU target adder and the instruction fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0010, PC loaded when a taken transfer has a misaligned target.
- FLUSH_CYCLES, 2, number of un-stalled cycles flush stays high after a redirect; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  fetch hold; PC does not advance while high.
- br_valid  input  1  a resolved control-transfer instruction is presented this cycle.
- br_taken  input  1  branch condition result from branch-condition select; meaningful only with br_valid.
- jump  input  1  unconditional transfer (jal/jalr); overrides br_taken.
- target  input  32  computed transfer target address.
- pc  output  32  current fetch address (registered).
- pc_seq  output  32  pc + 4 (combinational from pc, wraps mod 2^32).
- flush  output  1  squash fetch/decode contents (registered).
- redirect  output  1  one-cycle pulse: PC was loaded from target or TRAP_VEC this edge.
- misalign  output  1  one-cycle pulse: the redirect went to TRAP_VEC.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-flush):
  - pc = RESET_PC; flush = 0; redirect = 0; misalign = 0.
  - State = RUN; flush counter = 0.
- Qualification: take = br_valid & (jump | br_taken). br_taken is ignored when br_valid = 0.
- State RUN:
  - take = 1 and target[1:0] == 0 → next edge: pc <= target, redirect = 1, flush = 1, counter <= FLUSH_CYCLES-1, go to FLUSH.
  - take = 1 and target[1:0] != 0 → same as above, except pc <= TRAP_VEC and misalign = 1.
  - Otherwise, stall = 0 → pc <= pc + 4.
  - Otherwise, stall = 1 → pc holds.
  - redirect and misalign are 0 for both non-redirect cases.
- Priority: take beats stall. A redirect is never lost to a stall; pc loads even while stall = 1.
- State FLUSH:
  - flush = 1 throughout.
  - br_valid, br_taken and jump are ignored (they come from squashed instructions).
  - stall = 0: pc <= pc + 4; counter == 0 → go to RUN with flush <= 0; else counter decrements.
  - stall = 1: pc and counter hold, so flush is extended.
  - Net effect: flush covers exactly FLUSH_CYCLES un-stalled fetch slots.
- redirect and misalign are high for exactly one cycle, the cycle after the loading edge. They are never asserted in consecutive cycles, because FLUSH blocks back-to-back redirects.
- Arithmetic: pc + 4 wraps modulo 2^32. 32'hFFFF_FFFC advances to 32'h0000_0000, with no flag.
- br_valid = 1 with jump = 0 and br_taken = 0 is a normal advance; no flush.
- Simultaneous jump = 1 and br_taken = 0 → taken.
- Latency: one clock from take to new pc; flush is asserted on that same edge.

Test Plan:
- Reset/advance: assert rst, release; 3 cycles with stall = 0 → pc = 0x0, 0x4, 0x8, 0xC; flush, redirect and misalign all 0.
- Taken branch: pc = 0x8, br_valid = 1, br_taken = 1, target = 0x100.
  - Next cycle: pc = 0x100, redirect = 1, flush = 1.
  - Following cycle: pc = 0x104, flush = 1, redirect = 0.
  - Then pc = 0x108 with flush = 0.
- Not-taken and jump override: br_valid = 1, br_taken = 0, jump = 0 → pc advances by 4, no flush. Then jump = 1, br_taken = 0, target = 0x40 → pc = 0x40, redirect = 1.
- Misaligned target: br_valid = 1, jump = 1, target = 0x102 → pc = 0x10, misalign = 1 and redirect = 1 for one cycle, flush for 2 un-stalled cycles.
- Stall interaction:
  - Branch to 0x200 taken while stall = 1 → pc = 0x200 loaded.
  - Hold stall = 1 for 3 cycles → pc stays 0x200 and flush stays 1.
  - Release stall → flush drops after 2 further cycles.
  - A br_valid/br_taken pulse inside FLUSH with target = 0x300 → ignored.
- Async reset mid-flush and wrap: assert rst during FLUSH, between clock edges → pc = RESET_PC and flush = 0 immediately. Separately, redirect to 0xFFFF_FFFC, then advance → pc = 0x0000_0000.
